// File: rtl/bft_stream_packetizer.sv
// Packs a user stream into BFT packets with credit-based flow control.
// Optional transfer counter output pkt_count enabled by PACKETIZER_STATS_EN.
module bft_stream_packetizer #(
    parameter int unsigned PACKET_BITS           = 49,
    parameter int unsigned PAYLOAD_BITS          = 32,
    parameter int unsigned NUM_LEAF_BITS         = 5,
    parameter int unsigned NUM_PORT_BITS         = 4,
    parameter int unsigned NUM_ADDR_BITS         = 7,
    parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ap_start,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dst_port,
    input  logic [PAYLOAD_BITS-1:0]  din,
    input  logic                     din_vld,
    output logic                     din_ack,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
    input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
    output logic                     busy,
    output logic                     credit_err
`ifdef PACKETIZER_STATS_EN
    ,
    output logic [31:0]              pkt_count
`endif
);

    localparam int unsigned CREDIT_BITS = 8;
    localparam int unsigned SUM_BITS    = 16;
    localparam int unsigned MAX_CREDITS = 1 << NUM_ADDR_BITS;
    localparam int unsigned VALID_POS   = PACKET_BITS - 1;
    localparam int unsigned PORT_LSB    = PAYLOAD_BITS + NUM_ADDR_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state, state_next;
    logic [CREDIT_BITS-1:0]   credits, credits_next;
    logic [NUM_ADDR_BITS-1:0] addr, addr_next;
    logic [NUM_LEAF_BITS-1:0] leaf_q, leaf_next;
    logic [NUM_PORT_BITS-1:0] port_q, port_next;
    logic [PACKET_BITS-1:0]   dout_next;
    logic                     credit_err_next;
    logic [SUM_BITS-1:0]      credit_sum;
    logic                     xfer;
    logic                     credit_pkt;
    logic                     unused_rx_fields;

    assign busy    = (state == RUN);
    assign din_ack = (state == RUN) && (credits != '0);
    assign xfer    = din_vld & din_ack;

    // Credit returns are valid packets addressed to port 0; only honoured while running.
    assign credit_pkt = busy & din_leaf_bft2interface[VALID_POS]
                      & (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == '0);
    assign unused_rx_fields = ^din_leaf_bft2interface;

    // Next-state, credit accounting and packet formation.
    always_comb begin
        state_next      = state;
        credits_next    = credits;
        addr_next       = addr;
        leaf_next       = leaf_q;
        port_next       = port_q;
        credit_err_next = credit_err;
        dout_next       = '0;
        credit_sum      = SUM_BITS'(credits)
                        + (credit_pkt ? SUM_BITS'(FREESPACE_UPDATE_SIZE) : SUM_BITS'(0))
                        - SUM_BITS'(xfer);
        case (state)
            IDLE: begin
                if (ap_start) begin
                    state_next   = RUN;
                    leaf_next    = cfg_dst_leaf;
                    port_next    = cfg_dst_port;
                    credits_next = CREDIT_BITS'(MAX_CREDITS);
                    addr_next    = '0;
                end
            end
            RUN: begin
                if (xfer) begin
                    dout_next = PACKET_BITS'({1'b1, leaf_q, port_q, addr, din});
                    addr_next = addr + NUM_ADDR_BITS'(1);
                end
                if (credit_sum > SUM_BITS'(MAX_CREDITS)) begin
                    credits_next    = CREDIT_BITS'(MAX_CREDITS);
                    credit_err_next = 1'b1;
                end else begin
                    credits_next = CREDIT_BITS'(credit_sum);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= IDLE;
            credits                 <= '0;
            addr                    <= '0;
            leaf_q                  <= '0;
            port_q                  <= '0;
            credit_err              <= 1'b0;
            dout_leaf_interface2bft <= '0;
        end else begin
            state                   <= state_next;
            credits                 <= credits_next;
            addr                    <= addr_next;
            leaf_q                  <= leaf_next;
            port_q                  <= port_next;
            credit_err              <= credit_err_next;
            dout_leaf_interface2bft <= dout_next;
        end
    end

`ifdef PACKETIZER_STATS_EN
    // Transfers only happen in RUN, so the count naturally holds in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (xfer) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bft_stream_packetizer.sv
// Scoreboard bench for bft_stream_packetizer: driver pushes expected packets, monitor pops and compares.
module tb_bft_stream_packetizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ap_start;
    logic [4:0]  cfg_dst_leaf;
    logic [3:0]  cfg_dst_port;
    logic [31:0] din;
    logic        din_vld;
    logic        din_ack;
    logic [48:0] dout;
    logic [48:0] din_leaf;
    logic        busy;
    logic        credit_err;
`ifdef PACKETIZER_STATS_EN
    logic [31:0] pkt_count;
`endif

    bft_stream_packetizer dut (
        .clk                     (clk),
        .reset                   (reset),
        .ap_start                (ap_start),
        .cfg_dst_leaf            (cfg_dst_leaf),
        .cfg_dst_port            (cfg_dst_port),
        .din                     (din),
        .din_vld                 (din_vld),
        .din_ack                 (din_ack),
        .dout_leaf_interface2bft (dout),
        .din_leaf_bft2interface  (din_leaf),
        .busy                    (busy),
        .credit_err              (credit_err)
`ifdef PACKETIZER_STATS_EN
        ,
        .pkt_count               (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    logic [48:0] exp_q[$];
    int          checks = 0;
    int          passes = 0;
    logic        mon_en = 1'b0;
    logic [4:0]  leaf_m;
    logic [3:0]  port_m;
    logic [6:0]  addr_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every valid packet must match the head of the queue; otherwise output must be zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (dout[48]) begin
                if (exp_q.size() == 0) check("unexpected_pkt", 64'(dout), 64'h0);
                else check("pkt", 64'(dout), 64'(exp_q.pop_front()));
            end else begin
                check("idle_zero", 64'(dout), 64'h0);
            end
        end
    end

    // One cycle of stimulus; called and returns at posedge+1.
    task automatic do_cycle(input logic vld, input logic [31:0] d, input logic cv,
                            input logic [3:0] cp, input logic exp_ack);
        din_vld  = vld;
        din      = d;
        din_leaf = cv ? {1'b1, 5'h1f, cp, 7'h55, 32'hCAFE_F00D} : 49'h0;
        @(negedge clk);
        check("din_ack", 64'(din_ack), 64'(exp_ack));
        if (vld && exp_ack) begin
            exp_q.push_back({1'b1, leaf_m, port_m, addr_m, d});
            addr_m = addr_m + 7'd1;
        end
        @(posedge clk);
        #1;
        din_vld  = 1'b0;
        din_leaf = '0;
    endtask

    task automatic start(input logic [4:0] l, input logic [3:0] p, input logic from_idle);
        ap_start     = 1'b1;
        cfg_dst_leaf = l;
        cfg_dst_port = p;
        @(posedge clk);
        #1;
        ap_start = 1'b0;
        if (from_idle) begin
            leaf_m = l;
            port_m = p;
            addr_m = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        ap_start     = 1'b0;
        cfg_dst_leaf = '0;
        cfg_dst_port = '0;
        din          = '0;
        din_vld      = 1'b0;
        din_leaf     = '0;
        leaf_m       = '0;
        port_m       = '0;
        addr_m       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_din_ack", 64'(din_ack), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_credit_err", 64'(credit_err), 64'h0);
        @(posedge clk);
        #1;

        // IDLE: data and credit packets are ignored
        do_cycle(1'b1, 32'h1, 1'b0, 4'h0, 1'b0);
        do_cycle(1'b0, 32'h0, 1'b1, 4'h0, 1'b0);

        // Basic packet, then ap_start ignored while running
        start(5'd5, 4'd2, 1'b1);
        do_cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 4'h0, 1'b1);
        do_cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1);
        check("busy_run", 64'(busy), 64'h1);
        start(5'd9, 4'd7, 1'b0);
        do_cycle(1'b1, 32'h0000_1234, 1'b0, 4'h0, 1'b1);

        // 128-word burst drains all credits
        do_reset();
        start(5'd5, 4'd2, 1'b1);
        for (int i = 0; i < 128; i++) do_cycle(1'b1, 32'(i) * 32'h0101_0101, 1'b0, 4'h0, 1'b1);
        do_cycle(1'b1, 32'h5555_5555, 1'b0, 4'h0, 1'b0);
        // Non-zero port packets do not return credit
        do_cycle(1'b0, 32'h0, 1'b1, 4'h3, 1'b0);
        do_cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        // Credit packet restores 64, then another reaches exactly 128 without error
        do_cycle(1'b0, 32'h0, 1'b1, 4'h0, 1'b0);
        do_cycle(1'b0, 32'h0, 1'b1, 4'h0, 1'b1);
        check("no_err_at_128", 64'(credit_err), 64'h0);
        do_cycle(1'b1, 32'hA5A5_A5A5, 1'b0, 4'h0, 1'b1);
        check("addr_wrapped", 64'(addr_m), 64'h1);

        // Saturation: at 100 credits, transfer plus credit overflows
        do_reset();
        start(5'd17, 4'd8, 1'b1);
        for (int i = 0; i < 28; i++) do_cycle(1'b1, 32'h1000 + 32'(i), 1'b0, 4'h0, 1'b1);
        do_cycle(1'b1, 32'h0000_BEEF, 1'b1, 4'h0, 1'b1);
        do_cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1);
        check("credit_err_set", 64'(credit_err), 64'h1);
        for (int i = 0; i < 128; i++) do_cycle(1'b1, 32'h2000 + 32'(i), 1'b0, 4'h0, 1'b1);
        do_cycle(1'b1, 32'h3333_3333, 1'b0, 4'h0, 1'b0);
        check("credit_err_sticky", 64'(credit_err), 64'h1);

        // Reset mid-stream discards the pending packet and the in-flight transfer
        do_reset();
        start(5'd3, 4'd1, 1'b1);
        do_cycle(1'b1, 32'h0000_0001, 1'b0, 4'h0, 1'b1);
        reset   = 1'b1;
        din_vld = 1'b1;
        din     = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        din_vld = 1'b0;
        @(negedge clk);
        check("mid_rst_din_ack", 64'(din_ack), 64'h0);
        check("mid_rst_busy", 64'(busy), 64'h0);
        check("mid_rst_dout", 64'(dout), 64'h0);
        check("mid_rst_credit_err", 64'(credit_err), 64'h0);
        @(posedge clk);
        #1;
        do_cycle(1'b1, 32'h7777_7777, 1'b0, 4'h0, 1'b0);
        start(5'd6, 4'd4, 1'b1);
        do_cycle(1'b1, 32'h0000_0099, 1'b0, 4'h0, 1'b1);

`ifdef PACKETIZER_STATS_EN
        do_reset();
        start(5'd1, 4'd1, 1'b1);
        for (int i = 0; i < 10; i++) do_cycle(1'b1, 32'h4000 + 32'(i), 1'b0, 4'h0, 1'b1);
        do_cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1);
        check("pkt_count_10", 64'(pkt_count), 64'd10);
        do_reset();
        @(negedge clk);
        check("pkt_count_rst", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
